// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: serialises a multi-hot vector into a stream of binary
// indices, highest set bit first, one index per handshake.
module bit_scan_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  output logic [W-1:0] out_index,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [W:0]   remaining,
  output logic         empty_load
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W:0]   remaining_q, remaining_d;
  logic         empty_load_q, empty_load_d;

  logic [W-1:0] top_idx;
  logic [W:0]   load_count;
  logic         load_fire;
  logic         emit_fire;

  // Priority encoder: highest set bit of pending wins (later iterations override)
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) top_idx = W'(i);
    end
  end

  // Population count of the incoming vector seeds the remaining counter
  always_comb begin
    load_count = '0;
    for (int i = 0; i < N; i++) begin
      load_count = load_count + (W+1)'(load_data[i]);
    end
  end

  assign load_ready = enable && (state_q == IDLE);
  assign out_valid  = enable && (state_q == SCAN);
  assign out_last   = (state_q == SCAN) && (remaining_q == (W+1)'(1));
  assign out_index  = top_idx;
  assign remaining  = remaining_q;
  assign empty_load = empty_load_q;
  assign load_fire  = load_valid && load_ready;
  assign emit_fire  = out_valid && out_ready;

  // Next-state logic; empty_load defaults low so it can only pulse for one cycle
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    remaining_d  = remaining_q;
    empty_load_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          if (load_data != '0) begin
            pending_d   = load_data;
            remaining_d = load_count;
            state_d     = SCAN;
          end else begin
            empty_load_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (emit_fire) begin
          pending_d   = pending_q & ~({{(N-1){1'b0}}, 1'b1} << top_idx);
          remaining_d = remaining_q - (W+1)'(1);
          if (out_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything so no stale index survives it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      remaining_q  <= '0;
      empty_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      remaining_q  <= remaining_d;
      empty_load_q <= empty_load_d;
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed bench for bit_scan_encoder: per-cycle vector table plus a
// hand-written reset-during-scan sequence.
module tb_bit_scan_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic [2:0] out_index;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] remaining;
  logic       empty_load;

  int checks = 0;
  int failures = 0;

  bit_scan_encoder #(.N(8), .W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .remaining  (remaining),
    .empty_load (empty_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       lv;
    logic [7:0] ld;
    logic       ordy;
    logic       ov;
    logic [2:0] oi;
    logic       olast;
    logic [3:0] rem;
    logic       lr;
    logic       el;
  } row_t;

  row_t tbl[$];

  function automatic void add(input logic en, input logic lv, input logic [7:0] ld,
                              input logic ordy, input logic ov, input logic [2:0] oi,
                              input logic olast, input logic [3:0] rem,
                              input logic lr, input logic el);
    row_t r;
    r.en = en; r.lv = lv; r.ld = ld; r.ordy = ordy;
    r.ov = ov; r.oi = oi; r.olast = olast; r.rem = rem; r.lr = lr; r.el = el;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic [2:0] oi,
                            input logic olast, input logic [3:0] rem,
                            input logic lr, input logic el);
    check({tag, ".out_valid"},  int'(out_valid),  int'(ov));
    check({tag, ".out_index"},  int'(out_index),  int'(oi));
    check({tag, ".out_last"},   int'(out_last),   int'(olast));
    check({tag, ".remaining"},  int'(remaining),  int'(rem));
    check({tag, ".load_ready"}, int'(load_ready), int'(lr));
    check({tag, ".empty_load"}, int'(empty_load), int'(el));
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: en lv ld ordy | ov oi last rem lr el
    // Reset state, then 1010_0110 -> 7,5,2,1
    add(1, 0, 8'h00, 1,  0, 0, 0, 0, 1, 0);
    add(1, 1, 8'hA6, 1,  0, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1,  1, 7, 0, 4, 0, 0);
    add(1, 0, 8'h00, 1,  1, 5, 0, 3, 0, 0);
    add(1, 0, 8'h00, 1,  1, 2, 0, 2, 0, 0);
    add(1, 0, 8'h00, 1,  1, 1, 1, 1, 0, 0);
    // Back in IDLE; load 8'hFF
    add(1, 1, 8'hFF, 1,  0, 0, 0, 0, 1, 0);
    // 8'hFF with out_ready 0,1 per index: each index held once, then emitted
    for (int k = 7; k >= 0; k--) begin
      add(1, 0, 8'h00, 0,  1, k[2:0], (k == 0), 4'(k + 1), 0, 0);
      add(1, 0, 8'h00, 1,  1, k[2:0], (k == 0), 4'(k + 1), 0, 0);
    end
    // Zero vector: empty_load pulses one cycle, no out_valid
    add(1, 1, 8'h00, 1,  0, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1,  0, 0, 0, 0, 1, 1);
    add(1, 0, 8'h00, 1,  0, 0, 0, 0, 1, 0);
    // Single bit 0, with 8'h80 held back-to-back by the source
    add(1, 1, 8'h01, 1,  0, 0, 0, 0, 1, 0);
    add(1, 1, 8'h80, 1,  1, 0, 1, 1, 0, 0);
    add(1, 1, 8'h80, 1,  0, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1,  1, 7, 1, 1, 0, 0);
    add(1, 0, 8'h00, 1,  0, 0, 0, 0, 1, 0);
    // enable=0 in IDLE blocks a load
    add(0, 1, 8'hFF, 1,  0, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 1,  0, 0, 0, 0, 1, 0);
    // 0110_0000 with a 3-cycle enable gap after the first emit
    add(1, 1, 8'h60, 1,  0, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1,  1, 6, 0, 2, 0, 0);
    add(0, 1, 8'hFF, 1,  0, 5, 1, 1, 0, 0);
    add(0, 1, 8'hFF, 1,  0, 5, 1, 1, 0, 0);
    add(0, 1, 8'hFF, 1,  0, 5, 1, 1, 0, 0);
    add(1, 0, 8'h00, 1,  1, 5, 1, 1, 0, 0);
    add(1, 0, 8'h00, 1,  0, 0, 0, 0, 1, 0);

    reset = 1'b1; enable = 1'b1; load_data = 8'h00; load_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Each row: drive inputs, let them settle, compare, then take the edge
    foreach (tbl[i]) begin
      enable     = tbl[i].en;
      load_valid = tbl[i].lv;
      load_data  = tbl[i].ld;
      out_ready  = tbl[i].ordy;
      #1;
      check_outs($sformatf("row%0d", i), tbl[i].ov, tbl[i].oi, tbl[i].olast,
                 tbl[i].rem, tbl[i].lr, tbl[i].el);
      tick();
    end

    // Reset mid-scan: load 1100_0011, emit 7, then reset
    enable = 1'b1; out_ready = 1'b0; load_valid = 1'b1; load_data = 8'hC3;
    tick();
    load_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_outs("rst.first", 1, 7, 0, 4, 0, 0);
    tick();
    #1;
    check_outs("rst.second", 1, 6, 0, 3, 0, 0);
    reset = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_outs("rst.after", 0, 0, 0, 0, 1, 0);
    out_ready = 1'b1;
    tick();
    check_outs("rst.idle", 0, 0, 0, 0, 1, 0);
    load_valid = 1'b1; load_data = 8'h10;
    tick();
    load_valid = 1'b0;
    #1;
    check_outs("rst.fresh", 1, 4, 1, 1, 0, 0);
    tick();
    check_outs("rst.done", 0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_scan_encoder.md
# bit_scan_encoder

Sequential binary encoder for multi-hot vectors, the counterpart of the team's one-hot decoders. A loaded N-bit vector is emitted as a stream of W-bit binary indices, one per set bit, highest index first, with one index per cycle under a valid/ready handshake. It sits between switch/request sources and logic that consumes binary indices, such as a decoder feeding LEDs or an arbiter grant path.

## Interface
- N, default 8: input vector width; must equal 2**W
- W, default 3: index width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- enable  in  1  global enable; 0 freezes all state and blocks handshakes
- load_data  in  N  multi-hot vector to encode
- load_valid  in  1  load_data is valid
- load_ready  out  1  block accepts a load this cycle
- out_index  out  W  binary index of the highest set bit still pending
- out_valid  out  1  out_index is valid
- out_ready  in  1  consumer accepts out_index
- out_last  out  1  out_index is the final pending bit of this vector
- remaining  out  W+1  count of set bits still pending, including the one presented
- empty_load  out  1  one-cycle pulse: an all-zero vector was accepted

## Operation
- State: IDLE, SCAN. Registers: pending[N-1:0], remaining, empty_load.
- load_ready = enable && state==IDLE. out_valid = enable && state==SCAN.
- out_index = position of the highest set bit of pending; 0 when pending==0. The value is combinational from pending.
- out_last = (remaining==1) while in SCAN; 0 otherwise.
- IDLE, load fire (load_valid && load_ready):
  - load_data!=0: pending<=load_data, remaining<=popcount(load_data), then go to SCAN.
  - load_data==0: stay IDLE, empty_load<=1 for exactly one cycle, pending and remaining stay 0.
- SCAN, emit fire (out_valid && out_ready): clear pending[out_index] and decrement remaining.
  - If out_last is set, go to IDLE. pending and remaining are then 0.
- No load is accepted in SCAN. load_valid is ignored there and the source must hold its data.
- enable==0: no fire of either handshake; state, pending and remaining hold. empty_load is 0 in any cycle where no zero-vector load fired on the previous edge.
- Arithmetic: remaining is W+1 bits wide, so the maximum N (all ones) is representable. remaining never underflows because exit occurs at 1 to 0.
- Duplicate indices are never emitted. Indices within one vector are strictly decreasing.

## Timing
- Reset (sync) values: state=IDLE, pending=0, remaining=0, empty_load=0, out_valid=0, out_index=0, out_last=0. load_ready equals enable from the first cycle after reset.
- Latency: load fire at edge k; out_valid=1 and the first index are presented in cycle k+1.
- Throughput is 1 index/cycle while out_ready=1. A vector with P set bits occupies P cycles in SCAN.
- After the last emit fire at edge m, state is IDLE and load_ready=1 in cycle m+1. There is a one-cycle bubble between vectors.
- Back-pressure: with out_ready=0, out_index, out_last and remaining hold stable and out_valid stays 1.
- Reset asserted mid-SCAN: at the next edge the block returns to IDLE with pending cleared. No stale index appears after reset.
- reset has priority over enable and over both handshakes.
- Dropping enable mid-SCAN: out_valid falls in the same cycle. Raising enable again resumes at the same index, with no loss and no repeat.

## Test plan
- Reset, then load 8'b1010_0110 with out_ready=1 -> indices 7,5,2,1 on consecutive cycles; remaining 4,3,2,1; out_last only with index 1; load_ready=1 the cycle after.
- Load 8'hFF with out_ready toggling 1,0,1,0... -> indices 7..0 in order, each held while out_ready=0; remaining starts at 8.
- Load 8'h00 -> no out_valid; empty_load high for exactly one cycle; load_ready stays 1.
- Load 8'b0000_0001 -> single index 0 with out_last=1 and remaining=1; the back-to-back next load of 8'h80 is accepted after the one-cycle bubble and gives index 7.
- Load 8'b1100_0011, emit 7, then assert reset for 1 cycle -> out_valid=0, remaining=0, IDLE; no further indices; a fresh load of 8'h10 gives index 4.
- Load 8'b0110_0000, then drop enable for 3 cycles after the first emit -> out_valid=0 and load_ready=0 during the gap; after re-enable the next index is 5, then IDLE.
